uart_rcv_ctrl: RTL and testbench

UART_RCV_CTRL -- requirements
Module: uart_rcv_ctrl

---
 rtl/uart_rcv_ctrl.sv | 115 +++++++++++
 tb/tb_uart_rcv_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rcv_ctrl.sv
// UART receive controller: start-bit detect, mid-bit shift strobes, stop check, byte load with error flags.
// Latency: first strobe D+1.5 bit periods after the synchronized falling edge; rx_data valid 3 cycles after the stop-bit strobe.
// Backpressure: none; an unread byte is overwritten and flagged with overrun_error.
module uart_rcv_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS:0]   packet_data,
    input  logic                 data_read,
    output logic                 shift_strobe,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TMR_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMR_HALF_1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMR_HALF_2 = TW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CW-1:0] CNT_STOP   = CW'(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP_CHK, LOAD} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] bit_cnt;
    logic          sync_meta;
    logic          sync_cur;
    logic          sync_prev;
    logic          start_det;
    logic [TW-1:0] timer_nxt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_meta <= 1'b1;
            sync_cur  <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            sync_cur  <= sync_meta;
            sync_prev <= sync_cur;
        end
    end

    assign start_det = (state == IDLE) && sync_prev && !sync_cur;
    assign timer_nxt = (timer == TMR_LAST) ? '0 : timer + 1'b1;

    // The strobe is registered, so it is armed one cycle before the mid-bit point.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            timer         <= '0;
            bit_cnt       <= '0;
            shift_strobe  <= 1'b0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            shift_strobe <= 1'b0;
            if (data_read && state != LOAD) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state         <= START;
                        timer         <= '0;
                        bit_cnt       <= '0;
                        framing_error <= 1'b0;
                    end
                end
                START: begin
                    timer <= timer_nxt;
                    if (timer == TMR_HALF_1)
                        state <= sync_cur ? IDLE : DATA;
                end
                DATA: begin
                    timer <= timer_nxt;
                    if (timer == TMR_HALF_2)
                        shift_strobe <= 1'b1;
                    if (shift_strobe) begin
                        if (bit_cnt == CNT_STOP)
                            state <= STOP_CHK;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP_CHK: begin
                    if (packet_data[DATA_BITS]) begin
                        state <= LOAD;
                    end else begin
                        framing_error <= 1'b1;
                        state         <= IDLE;
                    end
                end
                LOAD: begin
                    rx_data    <= packet_data[DATA_BITS-1:0];
                    data_ready <= 1'b1;
                    if (data_ready && !data_read)
                        overrun_error <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rcv_ctrl.sv
// Bench for uart_rcv_ctrl: models the downstream shift register and scoreboards strobe times and loaded bytes.
module tb_uart_rcv_ctrl;

    localparam int CPB = 10;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          serial_in;
    logic [DB:0]   packet_data;
    logic          data_read;
    logic          shift_strobe;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          overrun_error;
    logic          framing_error;

    uart_rcv_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .packet_data   (packet_data),
        .data_read     (data_read),
        .shift_strobe  (shift_strobe),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DB-1:0] d;
        int            c;
    } load_t;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    exp_strobe[$];
    load_t exp_load[$];
    logic [DB-1:0] prev_rx = '0;
    logic          prev_dr = 1'b0;
    logic [DB:0]   sr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream shift register: shifts toward LSB, stop bit ends up in the MSB.
    always @(posedge clk) if (shift_strobe) sr <= {serial_in, sr[DB:1]};
    assign packet_data = sr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic hold(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge; strobe/load times are relative to that edge index.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int gap, input bit expect_load);
        int n;
        load_t l;
        n = cyc;
        for (int i = 0; i <= DB; i++) exp_strobe.push_back(n + 2 + (i + 1) * CPB + CPB / 2);
        if (expect_load) begin
            l.d = d;
            l.c = n + 2 + (DB + 1) * CPB + CPB / 2 + 3;
            exp_load.push_back(l);
        end
        serial_in = 1'b0;
        hold(CPB);
        for (int i = 0; i < DB; i++) begin
            serial_in = d[i];
            hold(CPB);
        end
        serial_in = stop;
        hold(CPB);
        serial_in = 1'b1;
        if (gap > 0) hold(gap);
    endtask

    task automatic read_pulse;
        data_read = 1'b1;
        hold(1);
        data_read = 1'b0;
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (shift_strobe) begin
                check("strobe_expected", 32'(exp_strobe.size() != 0), 1);
                if (exp_strobe.size() != 0) check("strobe_cycle", cyc, exp_strobe.pop_front());
            end
            if (rx_data != prev_rx || (data_ready && !prev_dr)) begin
                check("load_expected", 32'(exp_load.size() != 0), 1);
                if (exp_load.size() != 0) begin
                    load_t l;
                    l = exp_load.pop_front();
                    check("load_data", rx_data, l.d);
                    check("load_cycle", cyc, l.c);
                end
            end
        end
        prev_rx = rx_data;
        prev_dr = data_ready;
    end

    initial begin
        logic [DB-1:0] keep_rx;
        n_rst = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        hold(3);
        check("rst_strobe", shift_strobe, 0);
        check("rst_rx", rx_data, 0);
        check("rst_ready", data_ready, 0);
        check("rst_ovr", overrun_error, 0);
        check("rst_frm", framing_error, 0);
        n_rst = 1'b1;
        hold(2);

        // Nominal frame
        send_frame(8'hA5, 1'b1, CPB, 1);
        check("nom_rx", rx_data, 8'hA5);
        check("nom_ready", data_ready, 1);
        check("nom_ovr", overrun_error, 0);
        check("nom_frm", framing_error, 0);
        read_pulse();
        check("nom_read_clr", data_ready, 0);

        // Short glitch must not start a frame
        keep_rx = rx_data;
        serial_in = 1'b0;
        hold(3);
        serial_in = 1'b1;
        hold(3 * CPB);
        check("glitch_rx", rx_data, keep_rx);
        check("glitch_ready", data_ready, 0);
        check("glitch_frm", framing_error, 0);
        check("glitch_ovr", overrun_error, 0);

        // Framing error, then a good frame clears it
        send_frame(8'h3C, 1'b0, 2 * CPB, 0);
        check("frm_flag", framing_error, 1);
        check("frm_ready", data_ready, 0);
        check("frm_rx", rx_data, keep_rx);
        send_frame(8'h96, 1'b1, CPB, 1);
        check("frm_clear", framing_error, 0);
        check("frm_next_rx", rx_data, 8'h96);
        read_pulse();

        // Back-to-back frames without a read
        send_frame(8'h11, 1'b1, 0, 1);
        send_frame(8'h22, 1'b1, CPB, 1);
        check("ovr_rx", rx_data, 8'h22);
        check("ovr_ready", data_ready, 1);
        check("ovr_flag", overrun_error, 1);
        read_pulse();
        check("ovr_clr_ready", data_ready, 0);
        check("ovr_clr_flag", overrun_error, 0);
        read_pulse();
        check("read_noop", data_ready, 0);

        // data_read coinciding with LOAD while a byte is pending
        send_frame(8'h66, 1'b1, CPB, 1);
        check("pend_ready", data_ready, 1);
        fork
            send_frame(8'h55, 1'b1, CPB, 1);
            begin
                hold(2 + (DB + 1) * CPB + CPB / 2 + 2);
                read_pulse();
            end
        join
        check("simul_rx", rx_data, 8'h55);
        check("simul_ready", data_ready, 1);
        check("simul_ovr", overrun_error, 0);

        // Reset after the 4th strobe aborts the frame
        begin
            int n;
            logic [7:0] d;
            n = cyc;
            d = 8'hC3;
            for (int i = 0; i < 4; i++) exp_strobe.push_back(n + 2 + (i + 1) * CPB + CPB / 2);
            serial_in = 1'b0;
            hold(CPB);
            for (int i = 0; i < 4; i++) begin
                serial_in = d[i];
                hold(CPB);
            end
        end
        check("mid_strobes_seen", exp_strobe.size(), 0);
        n_rst = 1'b0;
        serial_in = 1'b1;
        #1;
        check("mid_rst_rx", rx_data, 0);
        check("mid_rst_ready", data_ready, 0);
        check("mid_rst_strobe", shift_strobe, 0);
        check("mid_rst_ovr", overrun_error, 0);
        check("mid_rst_frm", framing_error, 0);
        hold(3);
        n_rst = 1'b1;
        hold(8 * CPB);
        check("post_rst_ready", data_ready, 0);
        send_frame(8'h0F, 1'b1, CPB, 1);
        check("post_rst_rx", rx_data, 8'h0F);
        check("post_rst_rdy", data_ready, 1);

        hold(2 * CPB);
        check("strobe_q_empty", exp_strobe.size(), 0);
        check("load_q_empty", exp_load.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
